// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory port, redirect input and the
// decode-facing fetch buffer head. The master modport is the fetch unit side.
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fetch_fault;

  modport master (
    output imem_addr, out_valid, out_pc, out_instr, fetch_fault,
    input  imem_instr, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_pc, out_instr, fetch_fault,
    output imem_instr, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register feeding a 2-entry {pc, instr} buffer.
// Optional macro FETCH_MISALIGN_TRAP_EN turns misaligned redirects into a sticky fault.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic        clk,
  input logic        rst_n,
  fetch_unit_if.master fetchBus
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} occState_e;

  occState_e   occ_q, occ_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] headPc_q, headPc_d;
  logic [31:0] headInstr_q, headInstr_d;
  logic [31:0] tailPc_q, tailPc_d;
  logic [31:0] tailInstr_q, tailInstr_d;
  logic        push;
  logic        pop;
  logic        faulted;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q, fault_d;
  assign faulted = fault_q;
`else
  assign faulted = 1'b0;
`endif

  assign fetchBus.imem_addr   = pc_q;
  assign fetchBus.out_valid   = (occ_q != EMPTY);
  assign fetchBus.out_pc      = headPc_q;
  assign fetchBus.out_instr   = headInstr_q;
  assign fetchBus.fetch_fault = faulted;

  always_comb begin
    occ_d       = occ_q;
    pc_d        = pc_q;
    headPc_d    = headPc_q;
    headInstr_d = headInstr_q;
    tailPc_d    = tailPc_q;
    tailInstr_d = tailInstr_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    fault_d     = fault_q;
`endif
    pop  = (occ_q != EMPTY) && fetchBus.out_ready;
    push = 1'b0;

    if (fetchBus.redirect_valid) begin
      // Redirect wins over everything: buffered entries are dropped, any pop ignored.
      occ_d = EMPTY;
`ifdef FETCH_MISALIGN_TRAP_EN
      pc_d    = fetchBus.redirect_pc;
      fault_d = |fetchBus.redirect_pc[1:0];
`else
      pc_d = {fetchBus.redirect_pc[31:2], 2'b00};
`endif
    end else begin
      push = !faulted && ((occ_q != FULL) || pop);
      case (occ_q)
        EMPTY: begin
          if (push) begin
            headPc_d    = pc_q;
            headInstr_d = fetchBus.imem_instr;
            occ_d       = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            headPc_d    = pc_q;
            headInstr_d = fetchBus.imem_instr;
          end else if (push) begin
            tailPc_d    = pc_q;
            tailInstr_d = fetchBus.imem_instr;
            occ_d       = FULL;
          end else if (pop) begin
            occ_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            headPc_d    = tailPc_q;
            headInstr_d = tailInstr_q;
            if (push) begin
              tailPc_d    = pc_q;
              tailInstr_d = fetchBus.imem_instr;
            end else begin
              occ_d = ONE;
            end
          end
        end
        default: occ_d = EMPTY;
      endcase
      if (push) begin
        pc_d = pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q       <= EMPTY;
      pc_q        <= RESET_PC;
      headPc_q    <= 32'h0;
      headInstr_q <= 32'h0;
      tailPc_q    <= 32'h0;
      tailInstr_q <= 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q     <= 1'b0;
`endif
    end else begin
      occ_q       <= occ_d;
      pc_q        <= pc_d;
      headPc_q    <= headPc_d;
      headInstr_q <= headInstr_d;
      tailPc_q    <= tailPc_d;
      tailInstr_q <= tailInstr_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q     <= fault_d;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then random traffic,
// compared against a queue-based model of the fetch buffer.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n;
  int   assertCount = 0;
  int   failCount   = 0;

  logic [31:0] mPc;
  logic [63:0] mQ[$];
  bit          mFault;

  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .fetchBus(bus)
  );

  // Instruction memory holds its own word index: mem[i] = i.
  assign bus.imem_instr = {2'b00, bus.imem_addr[31:2]};

  task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    expectEq({tag, ".imem_addr"}, bus.imem_addr, mPc);
    expectEq({tag, ".out_valid"}, 32'(bus.out_valid), 32'(mQ.size() != 0));
    expectEq({tag, ".fetch_fault"}, 32'(bus.fetch_fault), 32'(mFault));
    if (mQ.size() != 0) begin
      expectEq({tag, ".out_pc"}, bus.out_pc, mQ[0][63:32]);
      expectEq({tag, ".out_instr"}, bus.out_instr, mQ[0][31:0]);
    end
  endtask

  // Drive one cycle of inputs, advance the model by the fetch rules, then check.
  task automatic applyStimulus(input bit rv, input logic [31:0] rpc, input bit rdy, input string tag);
    bit pop;
    bit push;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.out_ready      = rdy;
    pop = (mQ.size() != 0) && rdy;
    if (rv) begin
      mQ.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      mPc    = rpc;
      mFault = (rpc % 4) != 0;
`else
      mPc = rpc - (rpc % 4);
`endif
    end else begin
      push = !mFault && (mQ.size() < 2 || pop);
      if (pop) void'(mQ.pop_front());
      if (push) begin
        mQ.push_back({mPc, mPc / 4});
        mPc = mPc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic doReset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    mQ.delete();
    mPc    = RESET_PC;
    mFault = 1'b0;
    checkOutput({tag, ".inReset"});
    expectEq({tag, ".rstOutPc"}, bus.out_pc, 32'h0);
    expectEq({tag, ".rstOutInstr"}, bus.out_instr, 32'h0);
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput({tag, ".released"});
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.out_ready      = 1'b0;
    mPc                = RESET_PC;
    mFault             = 1'b0;

    #2;
    checkOutput("reset");
    expectEq("reset.out_pc0", bus.out_pc, 32'h0);
    expectEq("reset.out_instr0", bus.out_instr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("release");

    // Streaming from reset with decode always ready.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, "stream");
      expectEq("stream.pcSeq", bus.out_pc, RESET_PC + 32'(i * 4));
    end

    // Decode stalls: buffer fills with 0 and 4, fetch freezes at 8.
    doReset("stallRst");
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, 1'b0, "stall");
    expectEq("stall.addrFrozen", bus.imem_addr, 32'h8);
    expectEq("stall.headHeld", bus.out_pc, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, "drain");
    expectEq("drain.pc4", bus.out_pc, 32'h4);
    applyStimulus(1'b0, 32'h0, 1'b1, "drain");
    expectEq("drain.pc8", bus.out_pc, 32'h8);

    // Redirect while the buffer is full.
    applyStimulus(1'b0, 32'h0, 1'b0, "fill");
    applyStimulus(1'b1, 32'h100, 1'b1, "redir");
    expectEq("redir.flushed", 32'(bus.out_valid), 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, "redir");
    expectEq("redir.target", bus.out_pc, 32'h100);

    // Misaligned redirect.
    applyStimulus(1'b1, 32'h102, 1'b1, "misalign");
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, "faulted");
      expectEq("faulted.flag", 32'(bus.fetch_fault), 32'h1);
      expectEq("faulted.noValid", 32'(bus.out_valid), 32'h0);
    end
    applyStimulus(1'b1, 32'h200, 1'b1, "recover");
    applyStimulus(1'b0, 32'h0, 1'b1, "recover");
    expectEq("recover.target", bus.out_pc, 32'h200);
`else
    applyStimulus(1'b0, 32'h0, 1'b1, "misalign");
    expectEq("misalign.forced", bus.out_pc, 32'h100);
    expectEq("misalign.noFault", 32'(bus.fetch_fault), 32'h0);
`endif

    // PC wraps past the top of the address space.
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1, "wrap");
    applyStimulus(1'b0, 32'h0, 1'b1, "wrap");
    expectEq("wrap.top", bus.out_pc, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 32'h0, 1'b1, "wrap");
    expectEq("wrap.zero", bus.out_pc, 32'h0);

    // Asynchronous reset while full.
    applyStimulus(1'b0, 32'h0, 1'b0, "preRst");
    applyStimulus(1'b0, 32'h0, 1'b0, "preRst");
    applyStimulus(1'b0, 32'h0, 1'b0, "preRst");
    expectEq("preRst.full", 32'(bus.out_valid), 32'h1);
    doReset("midRst");
    applyStimulus(1'b0, 32'h0, 1'b1, "postRst");
    expectEq("postRst.resetPc", bus.out_pc, RESET_PC);

    // Random traffic with occasional (sometimes misaligned) redirects.
    for (int i = 0; i < 400; i++) begin
      bit          rv;
      bit          rdy;
      logic [31:0] rpc;
      rv  = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      applyStimulus(rv, rpc, rdy, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port imem_addr  output  32  fetch address to combinational instruction memory (word index = addr[31:2]).
REQ-005 SHALL have port imem_instr  input  32  instruction word returned same cycle for imem_addr.
REQ-006 SHALL have port redirect_valid  input  1  taken branch/jump; flush and refetch.
REQ-007 SHALL have port redirect_pc  input  32  redirect target.
REQ-008 SHALL have port out_valid  output  1  fetch buffer head valid toward decode.
REQ-009 SHALL have port out_ready  input  1  decode accepts head this cycle.
REQ-010 SHALL have port out_pc  output  32  PC of head entry.
REQ-011 SHALL have port out_instr  output  32  instruction of head entry.
REQ-012 SHALL have port fetch_fault  output  1  misaligned redirect detected; fetch halted.

Function
REQ-013 SHALL hold a fetch PC register; imem_addr SHALL equal the PC register combinationally.
REQ-014 SHALL contain a 2-entry FIFO of {pc, instr}; occupancy states EMPTY, ONE, FULL.
REQ-015 Push condition: not redirect, not faulted, and (occupancy < 2 or pop this cycle); push writes {PC, imem_instr}, PC <= PC + 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
REQ-016 Pop condition: out_valid && out_ready; head advances on the same edge.
REQ-017 Transitions: EMPTY->ONE on push; ONE->FULL on push without pop; ONE->EMPTY on pop without push; FULL->ONE on pop without push; simultaneous push+pop SHALL keep occupancy.
REQ-018 out_valid SHALL be high exactly when occupancy != EMPTY; out_pc/out_instr SHALL be stable while out_valid && !out_ready.
REQ-019 When full and no pop, PC SHALL hold and no push SHALL occur.
REQ-020 redirect_valid SHALL take priority over all: occupancy <= EMPTY, PC <= redirect_pc, no push, any pop that cycle ignored by FIFO state (entries discarded).
REQ-021 Latency: instruction at PC X SHALL appear on out_* one cycle after X is presented on imem_addr; sustained throughput one instruction per cycle when out_ready high.
REQ-022 First out_valid SHALL assert on the first rising edge after rst_n deasserts + 1, carrying out_pc = RESET_PC.

Reset
REQ-023 rst_n low SHALL asynchronously set PC = RESET_PC, occupancy = EMPTY, out_valid = 0, fetch_fault = 0, out_pc = 0, out_instr = 0.
REQ-024 Reset asserted mid-operation SHALL discard all buffered entries and any pending redirect.

Configuration
REQ-025 Macro FETCH_MISALIGN_TRAP_EN defined: redirect with redirect_pc[1:0] != 0 SHALL flush, set fetch_fault = 1 on next edge, stop pushes; fault clears on an aligned redirect, resuming fetch at that target.
REQ-026 Macro FETCH_MISALIGN_TRAP_EN undefined: redirect_pc[1:0] SHALL be forced to 2'b00 before loading PC; fetch_fault SHALL be tied 0.

Verification
REQ-027 Reset release, out_ready=1, mem[i]=i -> out_pc 0,4,8,... consecutive cycles, out_instr 0,1,2,...
REQ-028 out_ready=0 for 5 cycles after reset -> FIFO holds PC 0 and 4, imem_addr frozen at 8, out_pc stays 0; then out_ready=1 -> 0,4,8 no gaps.
REQ-029 redirect_valid with redirect_pc=32'h100 while FULL -> next cycle out_valid=0, following cycle out_pc=32'h100.
REQ-030 redirect_pc=32'h102: with macro -> fetch_fault=1, out_valid=0 indefinitely until redirect to 32'h200; without macro -> fetch from 32'h100.
REQ-031 redirect to 32'hFFFF_FFFC, out_ready=1 -> out_pc FFFF_FFFC then 0000_0000.
REQ-032 rst_n pulsed low while FULL -> out_valid=0 immediately; after release out_pc=RESET_PC.
